// File: rtl/isi_channel_pkg.sv
// Shared widths, tap-index width and the saturation range check used by
// the PAM-4 ISI channel model.
package isi_channel_pkg;

    localparam int DEFAULT_PULSE_RESPONSE_LENGTH = 2;
    localparam int DEFAULT_SIGNAL_RESOLUTION     = 8;
    localparam int COEF_GUARD_BITS               = 2;
    localparam int COEF_IDX_W                    = 8;
    localparam int SAT_CALC_W                    = 128;

    typedef enum logic [1:0] {
        SAT_NONE,
        SAT_HIGH,
        SAT_LOW
    } sat_e;

    // Products are W x (W+2) bits; summing L of them needs ceil(log2 L) extra bits.
    function automatic int acc_width(input int w, input int l);
        return 2 * w + COEF_GUARD_BITS + $clog2(l);
    endfunction

    function automatic sat_e sat_check(input logic signed [SAT_CALC_W-1:0] v,
                                       input int w);
        logic signed [SAT_CALC_W-1:0] hi;
        logic signed [SAT_CALC_W-1:0] lo;
        hi = (SAT_CALC_W'(1) <<< (w - 1)) - SAT_CALC_W'(1);
        lo = -hi - SAT_CALC_W'(1);
        if (v > hi) begin
            return SAT_HIGH;
        end
        if (v < lo) begin
            return SAT_LOW;
        end
        return SAT_NONE;
    endfunction

endpackage

// File: rtl/isi_round_sat.sv
// Converts the wide Q-format accumulator back to a W-bit sample:
// round half toward +inf, drop W fraction bits, clamp to the signed range.
module isi_round_sat
    import isi_channel_pkg::*;
#(
    parameter int W  = DEFAULT_SIGNAL_RESOLUTION,
    parameter int AW = acc_width(DEFAULT_SIGNAL_RESOLUTION, DEFAULT_PULSE_RESPONSE_LENGTH)
) (
    input  logic signed [AW-1:0] acc,
    output logic signed [W-1:0]  result
);

    localparam logic signed [AW:0] HALF = {{(AW + 1 - W){1'b0}}, 1'b1, {(W - 1){1'b0}}};

    logic signed [AW:0]           biased;
    logic signed [AW:0]           shifted;
    logic signed [SAT_CALC_W-1:0] wide;
    sat_e                         status;

    always_comb begin
        biased  = (AW + 1)'(acc) + HALF;
        shifted = biased >>> W;
        wide    = SAT_CALC_W'(shifted);
        status  = sat_check(wide, W);
        case (status)
            SAT_HIGH: result = {1'b0, {(W - 1){1'b1}}};
            SAT_LOW:  result = {1'b1, {(W - 1){1'b0}}};
            default:  result = shifted[W-1:0];
        endcase
    end

endmodule

// File: rtl/isi_channel.sv
// ISI channel model: FIR-convolves the PAM-4 level stream with a runtime
// loadable pulse response, two-stage pipeline, valid-qualified.
module isi_channel
    import isi_channel_pkg::*;
#(
    parameter int PULSE_RESPONSE_LENGTH = DEFAULT_PULSE_RESPONSE_LENGTH,
    parameter int SIGNAL_RESOLUTION     = DEFAULT_SIGNAL_RESOLUTION
) (
    input  logic                                                clk,
    input  logic                                                rstn,
    input  logic signed [SIGNAL_RESOLUTION-1:0]                 signal_in,
    input  logic                                                signal_in_valid,
    output logic signed [SIGNAL_RESOLUTION-1:0]                 signal_out,
    output logic                                                signal_out_valid,
    input  logic signed [SIGNAL_RESOLUTION+COEF_GUARD_BITS-1:0] channel_coefficient,
    input  logic        [COEF_IDX_W-1:0]                        channel_coefficient_idx
);

    localparam int L  = PULSE_RESPONSE_LENGTH;
    localparam int W  = SIGNAL_RESOLUTION;
    localparam int CW = W + COEF_GUARD_BITS;
    localparam int PW = W + CW;
    localparam int AW = acc_width(W, L);
    localparam int HL = (L > 1) ? L - 1 : 1;

    // Taps are deliberately excluded from reset so a loaded channel survives it.
    logic signed [CW-1:0] coef [L] = '{default: '0};
    logic signed [W-1:0]  hist [HL];
    logic signed [W-1:0]  tap_x [L];
    logic signed [PW-1:0] prod [L];
    logic                 valid_s1;
    logic signed [AW-1:0] acc;
    logic signed [W-1:0]  rounded;

    always_ff @(posedge clk) begin
        for (int k = 0; k < L; k++) begin
            if (channel_coefficient_idx == COEF_IDX_W'(k)) begin
                coef[k] <= channel_coefficient;
            end
        end
    end

    always_comb begin
        tap_x[0] = signal_in;
        for (int k = 1; k < L; k++) begin
            tap_x[k] = hist[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            hist <= '{default: '0};
        end else if (signal_in_valid) begin
            hist[0] <= signal_in;
            for (int k = 1; k < HL; k++) begin
                hist[k] <= hist[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            prod     <= '{default: '0};
            valid_s1 <= 1'b0;
        end else begin
            valid_s1 <= signal_in_valid;
            if (signal_in_valid) begin
                for (int k = 0; k < L; k++) begin
                    prod[k] <= PW'(coef[k]) * PW'(tap_x[k]);
                end
            end
        end
    end

    always_comb begin
        acc = '0;
        for (int k = 0; k < L; k++) begin
            acc = acc + AW'(prod[k]);
        end
    end

    isi_round_sat #(
        .W  (W),
        .AW (AW)
    ) u_round_sat (
        .acc    (acc),
        .result (rounded)
    );

    always_ff @(posedge clk) begin
        if (rstn) begin
            signal_out       <= '0;
            signal_out_valid <= 1'b0;
        end else begin
            signal_out_valid <= valid_s1;
            if (valid_s1) begin
                signal_out <= rounded;
            end
        end
    end

endmodule

// File: tb/tb_isi_channel.sv
// Directed bench for isi_channel: two-tap channel, hand-computed outputs
// for identity, ISI, saturation, gaps, parked index and mid-stream reset.
module tb_isi_channel;

    logic              clk = 1'b0;
    logic              rstn;
    logic signed [7:0] signal_in;
    logic              signal_in_valid;
    logic signed [7:0] signal_out;
    logic              signal_out_valid;
    logic signed [9:0] channel_coefficient;
    logic        [7:0] channel_coefficient_idx;

    int vectors     = 0;
    int miscompares = 0;

    isi_channel #(
        .PULSE_RESPONSE_LENGTH (2),
        .SIGNAL_RESOLUTION     (8)
    ) dut (
        .clk                     (clk),
        .rstn                    (rstn),
        .signal_in               (signal_in),
        .signal_in_valid         (signal_in_valid),
        .signal_out              (signal_out),
        .signal_out_valid        (signal_out_valid),
        .channel_coefficient     (channel_coefficient),
        .channel_coefficient_idx (channel_coefficient_idx)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn            = 1'b1;
        signal_in_valid = 1'b0;
        signal_in       = '0;
        tick();
        tick();
        rstn = 1'b0;
    endtask

    task automatic load_taps(input logic signed [9:0] h0, input logic signed [9:0] h1);
        channel_coefficient_idx = 8'd0;
        channel_coefficient     = h0;
        tick();
        channel_coefficient_idx = 8'd1;
        channel_coefficient     = h1;
        tick();
        channel_coefficient_idx = 8'hFF;
        channel_coefficient     = '0;
    endtask

    task automatic test_reset();
        rstn            = 1'b1;
        signal_in_valid = 1'b1;
        signal_in       = 8'sd100;
        tick();
        tick();
        vectors++;
        if (signal_out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_valid: got %b want 0", signal_out_valid);
        end
        vectors++;
        if (signal_out !== 8'sd0) begin
            miscompares++;
            $display("[TB] FAIL reset_out: got %0d want 0", signal_out);
        end
        rstn            = 1'b0;
        signal_in_valid = 1'b0;
        tick();
        vectors++;
        if (signal_out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_release_valid: got %b want 0", signal_out_valid);
        end
    endtask

    task automatic test_identity();
        logic signed [7:0] xs [3];
        xs = '{8'sd48, -8'sd72, 8'sd127};
        do_reset();
        load_taps(10'sd256, 10'sd0);
        for (int c = 0; c <= 3; c++) begin
            signal_in_valid = (c < 3);
            signal_in       = (c < 3) ? xs[c] : 8'sd0;
            tick();
            if (c > 0) begin
                vectors++;
                if (signal_out_valid !== 1'b1 || signal_out !== xs[c-1]) begin
                    miscompares++;
                    $display("[TB] FAIL identity[%0d]: got v=%b %0d want v=1 %0d",
                             c - 1, signal_out_valid, signal_out, xs[c-1]);
                end
            end
        end
        tick();
        vectors++;
        if (signal_out_valid !== 1'b0 || signal_out !== 8'sd127) begin
            miscompares++;
            $display("[TB] FAIL identity_hold: got v=%b %0d want v=0 127",
                     signal_out_valid, signal_out);
        end
    endtask

    task automatic test_isi();
        logic signed [7:0] xs [3];
        logic signed [7:0] ys [3];
        xs = '{8'sd48, 8'sd48, -8'sd72};
        ys = '{8'sd48, 8'sd53, -8'sd67};
        do_reset();
        load_taps(10'sd256, 10'sd26);
        for (int c = 0; c <= 3; c++) begin
            signal_in_valid = (c < 3);
            signal_in       = (c < 3) ? xs[c] : 8'sd0;
            tick();
            if (c > 0) begin
                vectors++;
                if (signal_out_valid !== 1'b1 || signal_out !== ys[c-1]) begin
                    miscompares++;
                    $display("[TB] FAIL isi[%0d]: got v=%b %0d want v=1 %0d",
                             c - 1, signal_out_valid, signal_out, ys[c-1]);
                end
            end
        end
    endtask

    task automatic test_saturation();
        logic signed [7:0] xs [2];
        load_taps(10'sd256, 10'sd256);
        for (int p = 0; p < 2; p++) begin
            xs = (p == 0) ? '{8'sd127, 8'sd127} : '{-8'sd128, -8'sd128};
            do_reset();
            for (int c = 0; c <= 2; c++) begin
                signal_in_valid = (c < 2);
                signal_in       = (c < 2) ? xs[c] : 8'sd0;
                tick();
                if (c > 0) begin
                    vectors++;
                    if (signal_out_valid !== 1'b1 || signal_out !== xs[c-1]) begin
                        miscompares++;
                        $display("[TB] FAIL sat[%0d][%0d]: got v=%b %0d want v=1 %0d",
                                 p, c - 1, signal_out_valid, signal_out, xs[c-1]);
                    end
                end
            end
        end
    endtask

    task automatic test_gapped();
        do_reset();
        load_taps(10'sd256, 10'sd26);
        for (int c = 0; c <= 6; c++) begin
            signal_in_valid = (c == 0 || c == 4);
            signal_in       = signal_in_valid ? 8'sd48 : -8'sd99;
            tick();
            if (c >= 1) begin
                vectors++;
                if (c == 1 || c == 5) begin
                    if (signal_out_valid !== 1'b1 || signal_out !== ((c == 1) ? 8'sd48 : 8'sd53)) begin
                        miscompares++;
                        $display("[TB] FAIL gapped_out@%0d: got v=%b %0d want v=1 %0d",
                                 c, signal_out_valid, signal_out, (c == 1) ? 48 : 53);
                    end
                end else if (signal_out_valid !== 1'b0 || signal_out !== ((c < 5) ? 8'sd48 : 8'sd53)) begin
                    miscompares++;
                    $display("[TB] FAIL gapped_idle@%0d: got v=%b %0d want v=0 %0d",
                             c, signal_out_valid, signal_out, (c < 5) ? 48 : 53);
                end
            end
        end
    endtask

    task automatic test_parked_idx();
        logic signed [7:0] xs [3];
        logic signed [7:0] ys [3];
        xs = '{8'sd48, 8'sd48, -8'sd72};
        ys = '{8'sd48, 8'sd53, -8'sd67};
        do_reset();
        load_taps(10'sd256, 10'sd26);
        channel_coefficient_idx = 8'hFF;
        channel_coefficient     = 10'sd511;
        for (int c = 0; c <= 3; c++) begin
            signal_in_valid = (c < 3);
            signal_in       = (c < 3) ? xs[c] : 8'sd0;
            tick();
            if (c > 0) begin
                vectors++;
                if (signal_out_valid !== 1'b1 || signal_out !== ys[c-1]) begin
                    miscompares++;
                    $display("[TB] FAIL parked[%0d]: got v=%b %0d want v=1 %0d",
                             c - 1, signal_out_valid, signal_out, ys[c-1]);
                end
            end
        end
        channel_coefficient = '0;
    endtask

    task automatic test_reset_midstream();
        do_reset();
        load_taps(10'sd256, 10'sd26);
        signal_in_valid = 1'b1;
        signal_in       = 8'sd48;
        tick();
        tick();
        rstn            = 1'b1;
        signal_in_valid = 1'b0;
        tick();
        vectors++;
        if (signal_out_valid !== 1'b0 || signal_out !== 8'sd0) begin
            miscompares++;
            $display("[TB] FAIL midreset_flush: got v=%b %0d want v=0 0",
                     signal_out_valid, signal_out);
        end
        rstn = 1'b0;
        tick();
        vectors++;
        if (signal_out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midreset_drop: got v=%b want 0", signal_out_valid);
        end
        signal_in_valid = 1'b1;
        signal_in       = 8'sd48;
        tick();
        signal_in_valid = 1'b0;
        tick();
        vectors++;
        if (signal_out_valid !== 1'b1 || signal_out !== 8'sd48) begin
            miscompares++;
            $display("[TB] FAIL midreset_first: got v=%b %0d want v=1 48",
                     signal_out_valid, signal_out);
        end
    endtask

    initial begin
        rstn                    = 1'b1;
        signal_in               = '0;
        signal_in_valid         = 1'b0;
        channel_coefficient     = '0;
        channel_coefficient_idx = 8'hFF;
        test_reset();
        test_identity();
        test_isi();
        test_saturation();
        test_gapped();
        test_parked_idx();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
